// File: rtl/mandel_iter_core.sv
// mandel_iter_core -- escape-time iterator for one point per transaction.
//
// Iterates z <- z^2 + c in signed fixed point Q(WIDTH-FRAC).FRAC. One signed
// multiplier is shared across three phases, so each iteration takes 3 cycles:
//   C1: zr*zi   C2: zr*zr   C3: zi*zi, escape test, z update, count
// Mandelbrot mode starts from z0 = 0 with c = point. Julia mode starts from
// z0 = point with c = julia constant.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   in_val / in_rdy       point handshake (in_rdy is a registered decode of IDLE)
//   in_pr, in_pi          point (c in Mandelbrot mode, z0 in Julia mode)
//   in_julia              mode select, sampled at accept
//   julia_cr, julia_ci    Julia constant, sampled at accept
//   max_iter              iteration limit, sampled at accept
//   in_tag                opaque tag returned with the result
//   out_val / out_rdy     result handshake
//   out_iter              completed iterations
//   out_escaped           1 = escaped, 0 = limit reached
//   out_tag               tag of the point
//   out_mag_sq            |z|^2 from the final C3 phase (only with
//                         MANDEL_ITER_MAG_OUT_EN defined)
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. in_rdy depends only on registered state. out_val stays high and all
// result outputs stay frozen until out_rdy is seen with out_val; after that
// edge the core returns to IDLE and in_rdy rises one cycle later.
//
// Optional build macro: MANDEL_ITER_MAG_OUT_EN adds the out_mag_sq output.

module mandel_iter_core #(
    parameter int WIDTH  = 27,
    parameter int FRAC   = 23,
    parameter int ITER_W = 10,
    parameter int TAG_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [WIDTH-1:0]  in_pr,
    input  logic [WIDTH-1:0]  in_pi,
    input  logic              in_julia,
    input  logic [WIDTH-1:0]  julia_cr,
    input  logic [WIDTH-1:0]  julia_ci,
    input  logic [ITER_W-1:0] max_iter,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
`ifdef MANDEL_ITER_MAG_OUT_EN
    output logic [WIDTH:0]    out_mag_sq,
`endif
    output logic [TAG_W-1:0]  out_tag
);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;
    typedef enum logic [1:0] {PH_C1, PH_C2, PH_C3} phase_t;

    // 2.0 and 4.0 at WIDTH+1 bits so magnitudes and |z| never overflow.
    localparam logic signed [WIDTH:0] TWO_X  = (WIDTH+1)'(2) << FRAC;
    localparam logic signed [WIDTH:0] FOUR_X = (WIDTH+1)'(4) << FRAC;

    state_t state_q, state_d;
    phase_t phase_q, phase_d;

    logic signed [WIDTH-1:0] zr_q, zi_q, cr_q, ci_q, zrzi_q, zr2_q;
    logic [ITER_W-1:0]       count_q, max_q;
    logic [TAG_W-1:0]        tag_q;
    logic                    escaped_q;
    logic                    out_val_q;
    logic                    in_rdy_q;

    logic accept, out_hs, done_set;

    assign accept = in_val && in_rdy_q;
    assign out_hs = out_val_q && out_rdy;

    // ------------------------------------------------------------------
    // Shared multiplier
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0]   mul_a, mul_b, mul_r;
    logic signed [2*WIDTH-1:0] mul_p;
    logic                      unused_mul_bits;

    always_comb begin
        mul_a = zi_q;
        mul_b = zi_q;
        case (phase_q)
            PH_C1: begin mul_a = zr_q; mul_b = zi_q; end
            PH_C2: begin mul_a = zr_q; mul_b = zr_q; end
            default: ;
        endcase
    end

    assign mul_p = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
    // Keep the sign and drop FRAC low bits: floor toward minus infinity.
    // The |z| <= 2 screening keeps every product that matters within range.
    assign mul_r = {mul_p[2*WIDTH-1], mul_p[WIDTH+FRAC-2:FRAC]};
    assign unused_mul_bits = ^{mul_p[2*WIDTH-2:WIDTH+FRAC-1], mul_p[FRAC-1:0]};

    // ------------------------------------------------------------------
    // C3 arithmetic: escape test and next z
    // ------------------------------------------------------------------
    logic signed [WIDTH:0]   zr_x, zi_x, zr_abs, zi_abs, mag;
    logic signed [WIDTH-1:0] zr_next, zi_next;
    logic [ITER_W-1:0]       cnt_inc;
    logic                    escape, limit_hit;

    assign zr_x    = {zr_q[WIDTH-1], zr_q};
    assign zi_x    = {zi_q[WIDTH-1], zi_q};
    assign zr_abs  = zr_x[WIDTH] ? -zr_x : zr_x;
    assign zi_abs  = zi_x[WIDTH] ? -zi_x : zi_x;
    assign mag     = {zr2_q[WIDTH-1], zr2_q} + {mul_r[WIDTH-1], mul_r};
    assign escape  = (zr_abs > TWO_X) || (zi_abs > TWO_X) || (mag > FOUR_X);
    assign zr_next = zr2_q - mul_r + cr_q;
    assign zi_next = (zrzi_q <<< 1) + ci_q;
    // count_q < max_q whenever C3 runs, so the increment never wraps.
    assign cnt_inc   = count_q + ITER_W'(1);
    assign limit_hit = (cnt_inc == max_q);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            phase_q <= PH_C1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (max_iter == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                        phase_d = PH_C1;
                    end
                end
            end
            ST_CALC: begin
                case (phase_q)
                    PH_C1: phase_d = PH_C2;
                    PH_C2: phase_d = PH_C3;
                    default: begin
                        phase_d = PH_C1;
                        if (escape || limit_hit) begin
                            state_d  = ST_DONE;
                            done_set = 1'b1;
                        end
                    end
                endcase
            end
            ST_DONE: begin
                if (out_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake flags and datapath registers
    // ------------------------------------------------------------------
`ifdef MANDEL_ITER_MAG_OUT_EN
    logic [WIDTH:0] mag_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            in_rdy_q  <= 1'b0;
            out_val_q <= 1'b0;
            zr_q      <= '0;
            zi_q      <= '0;
            cr_q      <= '0;
            ci_q      <= '0;
            zrzi_q    <= '0;
            zr2_q     <= '0;
            count_q   <= '0;
            max_q     <= '0;
            tag_q     <= '0;
            escaped_q <= 1'b0;
`ifdef MANDEL_ITER_MAG_OUT_EN
            mag_q     <= '0;
`endif
        end else begin
            in_rdy_q <= (state_d == ST_IDLE);

            // The max_iter==0 path enters DONE with out_val low, so its
            // result appears one cycle after DONE is entered.
            if (out_hs) begin
                out_val_q <= 1'b0;
            end else if (done_set || (state_q == ST_DONE)) begin
                out_val_q <= 1'b1;
            end

            if (accept) begin
                zr_q      <= in_julia ? $signed(in_pr) : '0;
                zi_q      <= in_julia ? $signed(in_pi) : '0;
                cr_q      <= in_julia ? $signed(julia_cr) : $signed(in_pr);
                ci_q      <= in_julia ? $signed(julia_ci) : $signed(in_pi);
                max_q     <= max_iter;
                tag_q     <= in_tag;
                count_q   <= '0;
                escaped_q <= 1'b0;
`ifdef MANDEL_ITER_MAG_OUT_EN
                mag_q     <= '0;
`endif
            end else if (state_q == ST_CALC) begin
                case (phase_q)
                    PH_C1: zrzi_q <= mul_r;
                    PH_C2: zr2_q  <= mul_r;
                    default: begin
`ifdef MANDEL_ITER_MAG_OUT_EN
                        mag_q <= mag;
`endif
                        if (escape) begin
                            escaped_q <= 1'b1;
                        end else begin
                            zr_q    <= zr_next;
                            zi_q    <= zi_next;
                            count_q <= cnt_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign in_rdy      = in_rdy_q;
    assign out_val     = out_val_q;
    assign out_iter    = count_q;
    assign out_escaped = escaped_q;
    assign out_tag     = tag_q;
`ifdef MANDEL_ITER_MAG_OUT_EN
    assign out_mag_sq  = mag_q;
`endif

endmodule

// File: doc/mandel_iter_core.md
Name: mandel_iter_core

Overview:
- Parametrised, runtime-configurable successor to the fixed-width escape-time iterator. It computes z <- z^2 + c for one point per transaction using a single shared signed multiplier, taking 3 cycles per iteration.
- Adds generic fixed-point width, a runtime iteration limit, a Julia mode and a pass-through tag.
- Instances are replicated in the pixel-farm behind the point dispatcher. The tag lets results return out of order.

Parameters:
WIDTH, 27, total signed fixed-point width of z, c and products (WIDTH-FRAC >= 4 required).
FRAC, 23, fractional bits (format Q(WIDTH-FRAC).FRAC; 2.0 = 2<<FRAC).
ITER_W, 10, width of iteration limit and count.
TAG_W, 16, width of pass-through tag.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge).
in_val  in  1  point valid.
in_rdy  out  1  core accepts a point (high exactly while state==IDLE).
in_pr  in  WIDTH  point real part (c in Mandelbrot mode, z0 in Julia mode).
in_pi  in  WIDTH  point imaginary part.
in_julia  in  1  mode select, sampled at accept: 0 = Mandelbrot (z0=0, c=point), 1 = Julia (z0=point, c=julia_c).
julia_cr  in  WIDTH  Julia constant, real part; sampled at accept.
julia_ci  in  WIDTH  Julia constant, imaginary part; sampled at accept.
max_iter  in  ITER_W  iteration limit; sampled at accept.
in_tag  in  TAG_W  opaque tag; sampled at accept.
out_val  out  1  result valid.
out_rdy  in  1  downstream ready.
out_iter  out  ITER_W  completed iterations.
out_escaped  out  1  1 = point escaped, 0 = limit reached.
out_tag  out  TAG_W  tag of the point.

Behaviour:
- Reset values: state IDLE, calc phase C1, in_rdy 0 during reset, out_val 0, out_iter 0, out_escaped 0, out_tag 0, internal z/c/product registers 0.
- After reset deasserts, in_rdy=1 (decoded from registered state, no combinational path from inputs).

States:
- IDLE: accept on in_val&&in_rdy. Latch c, z0, max_iter and tag; clear count.
  - If max_iter==0: go to DONE with out_iter=0, out_escaped=0.
  - Otherwise go to CALC/C1.
- CALC, phase C1: product zr*zi -> zrzi_reg.
- CALC, phase C2: product zr*zr -> zr2_reg.
- CALC, phase C3: product zi*zi forms zi2; mag = zr2_reg + zi2 computed at WIDTH+1 bits.
  - Escape if |zr| > 2.0, |zi| > 2.0, or mag > 4.0 (strict compares). Escape -> DONE, escaped=1, count unchanged.
  - Otherwise: zr <= zr2_reg - zi2 + cr; zi <= (zrzi_reg <<< 1) + ci; count++.
  - If the new count == max_iter -> DONE, escaped=0. Else -> C1.
- DONE: out_val=1. Results are held stable until out_val&&out_rdy, then -> IDLE. in_rdy rises the following cycle; there is no accept in the handshake cycle.

Multiplier:
- Full 2*WIDTH-bit signed product p.
- Result = {p[2*WIDTH-1], p[WIDTH+FRAC-2:FRAC]}, i.e. truncation toward minus infinity.
- The pre-multiply |z| <= 2 checks guarantee products <= 4.0, so no overflow.
- Callers keep |c| <= 2.0. Larger c escapes on the next iteration with no wrap, since z = c stays representable.

Timing:
- Latency from accept to out_val = 3*N + 1 cycles, where N = number of C3 phases executed.
- out_iter = N on limit; N-1 on escape.
- max_iter==0 case: out_val 2 cycles after accept.

Boundaries:
- max_iter = 2^ITER_W - 1 must not wrap the count.
- Exact |z|^2 == 4.0 does not escape.
- in_val during CALC/DONE is ignored (in_rdy=0).
- out_rdy held high before DONE has no effect.
- Reset asserted mid-CALC or mid-DONE aborts the point: out_val 0, nothing emitted, IDLE after release.

Optional Feature:
- Macro MANDEL_ITER_MAG_OUT_EN.
- When defined: adds output out_mag_sq [WIDTH:0], the mag value from the final C3 phase, for smooth colouring.
  - Reset value 0; held with the other results.
  - On the max_iter==0 path it is 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Mandelbrot, WIDTH=27/FRAC=23, c=(2.0,0), max_iter=50 -> out_iter=2, out_escaped=1, out_val 10 cycles after accept (z: 0 -> 2 -> 6, escape on |zr|>2).
- Mandelbrot c=(-1.0,0), max_iter=50, tag=0xBEEF -> out_iter=50, out_escaped=0, out_tag=0xBEEF, out_val 151 cycles after accept.
- Julia julia_c=(0,0): point (3.0,0) -> out_iter=0, out_escaped=1 after 4 cycles; point (0.5,0), max_iter=20 -> out_iter=20, out_escaped=0.
- max_iter=0, any point -> out_iter=0, out_escaped=0, out_val 2 cycles after accept.
- Backpressure: hold out_rdy=0 for 20 cycles in DONE -> out_val and outputs stable, in_rdy=0 throughout; pulse out_rdy -> in_rdy=1 next cycle; a second point with different tag completes correctly.
- Reset low for 1 cycle during CALC of c=(-1,0) -> out_val stays 0, in_rdy=0 while reset low, in_rdy=1 the cycle after release; no stale result emitted.
